// File: rtl/lsu_stage.sv
// Load/store unit behind the execute-stage ALU. It handles one memory op at a time.
// It checks legality, drives a single-outstanding memory port and extends load data for writeback.
module lsu_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [2:0]  in_funct3,
    input  logic        in_is_store,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        is_store_q, is_store_d;
    logic        in_ready_q, in_ready_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        req_wen_q, req_wen_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [3:0]  req_wmask_q, req_wmask_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_rdata_q, out_rdata_d;
    logic        out_err_q, out_err_d;

    function automatic logic op_legal(input logic store, input logic [2:0] f3,
                                      input logic [1:0] off);
        case (f3)
            3'b000:  return 1'b1;
            3'b001:  return ~off[0];
            3'b010:  return off == 2'b00;
            3'b100:  return ~store;
            3'b101:  return ~store & ~off[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'b0, sh[7:0]};
            3'b101:  return {16'b0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        is_store_d  = is_store_q;
        in_ready_d  = in_ready_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_wen_d   = req_wen_q;
        req_wdata_d = req_wdata_q;
        req_wmask_d = req_wmask_q;
        out_valid_d = out_valid_q;
        out_rdata_d = out_rdata_q;
        out_err_d   = out_err_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    off_d      = in_addr[1:0];
                    funct3_d   = in_funct3;
                    is_store_d = in_is_store;
                    in_ready_d = 1'b0;
                    if (op_legal(in_is_store, in_funct3, in_addr[1:0])) begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                        req_addr_d  = {in_addr[31:2], 2'b00};
                        req_wen_d   = in_is_store;
                        req_wdata_d = in_is_store ? (in_wdata << {in_addr[1:0], 3'b000}) : 32'h0;
                        req_wmask_d = in_is_store ? store_mask(in_funct3[1:0], in_addr[1:0]) : 4'h0;
                    end else begin
                        // Illegal ops skip memory entirely and report the error straight away
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b1;
                        out_rdata_d = 32'h0;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d     = WAIT_RSP;
                    req_valid_d = 1'b0;
                    cnt_d       = 16'h0;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b0;
                    out_rdata_d = is_store_q ? 32'h0 : load_extend(funct3_q, off_q, mem_rsp_rdata);
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q + 16'd1 == TIMEOUT_CNT) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b1;
                        out_rdata_d = 32'h0;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_rdata_d = 32'h0;
                    out_err_d   = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 16'h0;
            off_q       <= 2'b00;
            funct3_q    <= 3'b000;
            is_store_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            req_valid_q <= 1'b0;
            req_addr_q  <= 32'h0;
            req_wen_q   <= 1'b0;
            req_wdata_q <= 32'h0;
            req_wmask_q <= 4'h0;
            out_valid_q <= 1'b0;
            out_rdata_q <= 32'h0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            is_store_q  <= is_store_d;
            in_ready_q  <= in_ready_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_wen_q   <= req_wen_d;
            req_wdata_q <= req_wdata_d;
            req_wmask_q <= req_wmask_d;
            out_valid_q <= out_valid_d;
            out_rdata_q <= out_rdata_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wen   = req_wen_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_wmask = req_wmask_q;
    assign out_valid     = out_valid_q;
    assign out_rdata     = out_rdata_q;
    assign out_err       = out_err_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: a vector table of single ops on a zero-wait memory,
// plus hand sequences for backpressure, timeout, writeback stall and mid-op reset.
module tb_lsu_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [2:0]  in_funct3;
    logic        in_is_store;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_err;

    int checks = 0;
    int failures = 0;

    lsu_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_funct3(in_funct3), .in_is_store(in_is_store),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        is_store;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s[%0d] actual=%h required=%h", name, idx, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startOp(input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        in_valid    = 1'b1;
        in_is_store = st;
        in_funct3   = f3;
        in_addr     = addr;
        in_wdata    = wd;
    endtask

    // Runs one op against a memory that accepts immediately and responds one cycle later
    task automatic applyStimulus(input vec_t v, input int idx);
        bit req_seen;
        bit rsp_pending;
        bit done;
        int lat;
        req_seen = 0;
        rsp_pending = 0;
        done = 0;
        lat = 0;
        checkOutput("idle_in_ready", idx, 32'(in_ready), 32'd1);
        startOp(v.is_store, v.funct3, v.addr, v.wdata);
        mem_req_ready = 1'b1;
        out_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
            tick();
            in_valid = 1'b0;
            mem_rsp_valid = rsp_pending;
            mem_rsp_rdata = v.rsp;
            rsp_pending = 0;
            if (mem_req_valid) begin
                req_seen = 1;
                rsp_pending = 1;
                checkOutput("req_addr", idx, mem_req_addr, v.exp_addr);
                checkOutput("req_wen", idx, 32'(mem_req_wen), 32'(v.is_store));
                checkOutput("req_wmask", idx, 32'(mem_req_wmask), 32'(v.exp_wmask));
                if (v.is_store)
                    checkOutput("req_wdata", idx, mem_req_wdata, v.exp_wdata);
            end
            if (out_valid) begin
                done = 1;
                lat = cyc;
                checkOutput("out_rdata", idx, out_rdata, v.exp_rdata);
                checkOutput("out_err", idx, 32'(out_err), 32'(v.exp_err));
            end
        end
        mem_rsp_valid = 1'b0;
        checkOutput("latency", idx, 32'(lat), 32'(v.exp_req ? 3 : 1));
        checkOutput("req_issued", idx, 32'(req_seen), 32'(v.exp_req));
        tick();
        checkOutput("out_valid_drop", idx, 32'(out_valid), 32'd0);
        checkOutput("in_ready_back", idx, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        vecs[0]  = '{1'b0, 3'd2, 32'h80000004, 32'h0, 32'hDEADBEEF, 1'b1, 32'h80000004, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b0, 3'd0, 32'h80000003, 32'h0, 32'h80FF1234, 1'b1, 32'h80000000, 32'h0, 4'h0, 32'hFFFFFF80, 1'b0};
        vecs[2]  = '{1'b0, 3'd4, 32'h80000003, 32'h0, 32'h80FF1234, 1'b1, 32'h80000000, 32'h0, 4'h0, 32'h00000080, 1'b0};
        vecs[3]  = '{1'b0, 3'd1, 32'h80000002, 32'h0, 32'h80FF1234, 1'b1, 32'h80000000, 32'h0, 4'h0, 32'hFFFF80FF, 1'b0};
        vecs[4]  = '{1'b0, 3'd5, 32'h80000002, 32'h0, 32'h80FF1234, 1'b1, 32'h80000000, 32'h0, 4'h0, 32'h000080FF, 1'b0};
        vecs[5]  = '{1'b0, 3'd0, 32'h80000000, 32'h0, 32'h0000007F, 1'b1, 32'h80000000, 32'h0, 4'h0, 32'h0000007F, 1'b0};
        vecs[6]  = '{1'b1, 3'd0, 32'h80000001, 32'h000000AB, 32'h12345678, 1'b1, 32'h80000000, 32'h0000AB00, 4'b0010, 32'h0, 1'b0};
        vecs[7]  = '{1'b1, 3'd1, 32'h80000002, 32'h0000BEEF, 32'h12345678, 1'b1, 32'h80000000, 32'hBEEF0000, 4'b1100, 32'h0, 1'b0};
        vecs[8]  = '{1'b1, 3'd2, 32'h80000008, 32'hCAFEF00D, 32'h0, 1'b1, 32'h80000008, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 3'd2, 32'h80000002, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1};
        vecs[10] = '{1'b1, 3'd1, 32'h80000001, 32'h1234, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1};
        vecs[11] = '{1'b0, 3'd3, 32'h80000000, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1};
        vecs[12] = '{1'b1, 3'd4, 32'h80000000, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1};
        vecs[13] = '{1'b0, 3'd5, 32'h80000003, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1};
        vecs[14] = '{1'b1, 3'd2, 32'h80000003, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1};
        vecs[15] = '{1'b0, 3'd1, 32'h80000001, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_addr = 32'h0;
        in_wdata = 32'h0;
        in_funct3 = 3'd0;
        in_is_store = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        out_ready = 1'b0;
        repeat (3) tick();
        checkOutput("rst_in_ready", 0, 32'(in_ready), 32'd1);
        checkOutput("rst_req_valid", 0, 32'(mem_req_valid), 32'd0);
        checkOutput("rst_out_valid", 0, 32'(out_valid), 32'd0);
        checkOutput("rst_wmask", 0, 32'(mem_req_wmask), 32'd0);
        checkOutput("rst_out_err", 0, 32'(out_err), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++)
            applyStimulus(vecs[i], i);

        // Request backpressure for five cycles, then a lost response times out
        startOp(1'b1, 3'd0, 32'h80000002, 32'h00000055);
        mem_req_ready = 1'b0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_req_valid", i, 32'(mem_req_valid), 32'd1);
            checkOutput("bp_req_addr", i, mem_req_addr, 32'h80000000);
            checkOutput("bp_req_wdata", i, mem_req_wdata, 32'h00550000);
            checkOutput("bp_req_wmask", i, 32'(mem_req_wmask), 32'b0100);
            checkOutput("bp_req_wen", i, 32'(mem_req_wen), 32'd1);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        checkOutput("to_req_dropped", 0, 32'(mem_req_valid), 32'd0);
        checkOutput("to_not_done", 0, 32'(out_valid), 32'd0);
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        checkOutput("to_latency", 0, 32'(lat), 32'd4);
        checkOutput("to_err", 0, 32'(out_err), 32'd1);
        checkOutput("to_rdata", 0, out_rdata, 32'h0);
        tick();
        checkOutput("to_in_ready", 0, 32'(in_ready), 32'd1);

        // Writeback stall with a stray response that must not disturb the held result
        startOp(1'b0, 3'd2, 32'h80000010, 32'h0);
        mem_req_ready = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        checkOutput("st_req_valid", 0, 32'(mem_req_valid), 32'd1);
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h01234567;
        tick();
        mem_rsp_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            checkOutput("st_out_valid", i, 32'(out_valid), 32'd1);
            checkOutput("st_out_rdata", i, out_rdata, 32'h01234567);
            checkOutput("st_out_err", i, 32'(out_err), 32'd0);
            checkOutput("st_in_ready", i, 32'(in_ready), 32'd0);
            if (i < 2) tick();
        end
        mem_rsp_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("st_out_drop", 0, 32'(out_valid), 32'd0);
        checkOutput("st_in_ready_back", 0, 32'(in_ready), 32'd1);

        // Response arriving on the timeout cycle still completes without error
        startOp(1'b0, 3'd2, 32'h80000030, 32'h0);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        checkOutput("race_not_done", 0, 32'(out_valid), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hA5A5A5A5;
        tick();
        mem_rsp_valid = 1'b0;
        checkOutput("race_out_valid", 0, 32'(out_valid), 32'd1);
        checkOutput("race_out_err", 0, 32'(out_err), 32'd0);
        checkOutput("race_out_rdata", 0, out_rdata, 32'hA5A5A5A5);
        tick();
        checkOutput("race_in_ready", 0, 32'(in_ready), 32'd1);

        // Reset while waiting for a response, then a late response is ignored
        startOp(1'b0, 3'd2, 32'h80000020, 32'h0);
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        checkOutput("rr_in_ready", 0, 32'(in_ready), 32'd1);
        checkOutput("rr_out_valid", 0, 32'(out_valid), 32'd0);
        checkOutput("rr_req_valid", 0, 32'(mem_req_valid), 32'd0);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h11111111;
        tick();
        mem_rsp_valid = 1'b0;
        checkOutput("rr_late_out_valid", 0, 32'(out_valid), 32'd0);
        checkOutput("rr_late_in_ready", 0, 32'(in_ready), 32'd1);
        tick();
        checkOutput("rr_late_out_valid", 1, 32'(out_valid), 32'd0);
        checkOutput("rr_late_req_valid", 1, 32'(mem_req_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
